// File: rtl/operand_read_pkg.sv
// Shared definitions for the operand read sequencer: FSM state encoding and
// the shift codes applied to operand B.
package operand_read_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    READ_A = 2'b01,
    READ_B = 2'b10,
    HOLD   = 2'b11
  } state_e;

  localparam logic [1:0] SH_NONE = 2'b00;
  localparam logic [1:0] SH_LSL  = 2'b01;
  localparam logic [1:0] SH_LSR  = 2'b10;
  localparam logic [1:0] SH_ASR  = 2'b11;

endpackage

// File: rtl/operand_read_if.sv
// Request/response bundle between the issuing stage, the operand read
// sequencer and the ALU stage that consumes the operands.
interface operand_read_if #(
  parameter int width = 16
) ();

  logic             req_valid;
  logic             req_ready;
  logic [2:0]       rn;
  logic [2:0]       rm;
  logic [1:0]       shift;
  logic             out_valid;
  logic             out_ready;
  logic [width-1:0] a_out;
  logic [width-1:0] b_out;

  modport master (
    output req_valid, rn, rm, shift, out_ready,
    input  req_ready, out_valid, a_out, b_out
  );

  modport slave (
    input  req_valid, rn, rm, shift, out_ready,
    output req_ready, out_valid, a_out, b_out
  );

endinterface

// File: rtl/operand_read_shifter.sv
// Single-bit shifter for operand B; purely combinational so the ALU stage
// can reuse it unchanged.
module operand_shifter
  import operand_read_pkg::*;
#(
  parameter int width = 16
) (
  input  logic [width-1:0] b_i,
  input  logic [1:0]       shift_i,
  output logic [width-1:0] b_o
);

  always_comb begin
    b_o = b_i;
    case (shift_i)
      SH_LSL:  b_o = {b_i[width-2:0], 1'b0};
      SH_LSR:  b_o = {1'b0, b_i[width-1:1]};
      SH_ASR:  b_o = {b_i[width-1], b_i[width-1:1]};
      default: b_o = b_i;
    endcase
  end

endmodule

// File: rtl/operand_read.sv
// Register-file read sequencer: fetches A then B over two cycles with
// write-port forwarding, shifts B, and holds both until the ALU takes them.
module operand_read
  import operand_read_pkg::*;
#(
  parameter int width = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  operand_read_if.slave    bus,
  input  logic [width-1:0] reg0,
  input  logic [width-1:0] reg1,
  input  logic [width-1:0] reg2,
  input  logic [width-1:0] reg3,
  input  logic [width-1:0] reg4,
  input  logic [width-1:0] reg5,
  input  logic [width-1:0] reg6,
  input  logic [width-1:0] reg7,
  input  logic             write,
  input  logic [2:0]       writenum,
  input  logic [width-1:0] write_data
);

  state_e           state_q, state_d;
  logic [2:0]       rn_q, rn_d;
  logic [2:0]       rm_q, rm_d;
  logic [1:0]       shift_q, shift_d;
  logic [width-1:0] a_q, a_d;
  logic [width-1:0] b_q, b_d;

  logic [2:0]       sel_num;
  logic [width-1:0] sel_data;
  logic [width-1:0] shifted_b;

  // One shared read port: A's register in READ_A, B's otherwise; a write
  // committing this cycle overrides the stale register value.
  always_comb begin
    sel_num  = (state_q == READ_A) ? rn_q : rm_q;
    sel_data = reg0;
    case (sel_num)
      3'd0: sel_data = reg0;
      3'd1: sel_data = reg1;
      3'd2: sel_data = reg2;
      3'd3: sel_data = reg3;
      3'd4: sel_data = reg4;
      3'd5: sel_data = reg5;
      3'd6: sel_data = reg6;
      3'd7: sel_data = reg7;
      default: sel_data = reg0;
    endcase
    if (write && (writenum == sel_num)) begin
      sel_data = write_data;
    end
  end

  operand_shifter #(.width(width)) u_shifter (
    .b_i     (sel_data),
    .shift_i (shift_q),
    .b_o     (shifted_b)
  );

  always_comb begin
    state_d = state_q;
    rn_d    = rn_q;
    rm_d    = rm_q;
    shift_d = shift_q;
    a_d     = a_q;
    b_d     = b_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          rn_d    = bus.rn;
          rm_d    = bus.rm;
          shift_d = bus.shift;
          state_d = READ_A;
        end
      end
      READ_A: begin
        a_d     = sel_data;
        state_d = READ_B;
      end
      READ_B: begin
        b_d     = shifted_b;
        state_d = HOLD;
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      rn_q    <= '0;
      rm_q    <= '0;
      shift_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      rn_q    <= rn_d;
      rm_q    <= rm_d;
      shift_q <= shift_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  // Handshake outputs come straight from registered state.
  assign bus.req_ready = (state_q == IDLE);
  assign bus.out_valid = (state_q == HOLD);
  assign bus.a_out     = a_q;
  assign bus.b_out     = b_q;

endmodule

// File: tb/tb_operand_read.sv
// Self-checking bench for operand_read: directed test-plan steps followed by
// randomized requests checked against a behavioural register-file model.
module tb_operand_read;

  logic        clk;
  logic        reset_n;
  logic [15:0] regs [8];
  logic        write;
  logic [2:0]  writenum;
  logic [15:0] write_data;

  int checks;
  int fails;

  operand_read_if #(.width(16)) bus ();

  operand_read #(.width(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus.slave),
    .reg0       (regs[0]),
    .reg1       (regs[1]),
    .reg2       (regs[2]),
    .reg3       (regs[3]),
    .reg4       (regs[4]),
    .reg5       (regs[5]),
    .reg6       (regs[6]),
    .reg7       (regs[7]),
    .write      (write),
    .writenum   (writenum),
    .write_data (write_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference shift computed arithmetically on the unsigned 16-bit value.
  function automatic logic [15:0] shiftRef(input logic [15:0] b, input logic [1:0] sh);
    int unsigned v;
    v = b;
    case (sh)
      2'd1:    return 16'((v * 2) % 65536);
      2'd2:    return 16'(v / 2);
      2'd3:    return 16'(v / 2 + ((v >= 32768) ? 32768 : 0));
      default: return b;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("[TB] %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full transaction from IDLE (called just after a falling edge) back
  // to IDLE, with optional write-port activity during each read cycle.
  task automatic applyStimulus(input string tag,
                               input logic [2:0] rn, input logic [2:0] rm, input logic [1:0] sh,
                               input logic aWr, input logic [2:0] aWn, input logic [15:0] aWd,
                               input logic bWr, input logic [2:0] bWn, input logic [15:0] bWd,
                               input int holdCycles);
    logic [15:0] expA;
    logic [15:0] expB;
    logic [15:0] srcB;
    checkOutput({tag, ".idleReady"}, {15'b0, bus.req_ready}, 16'h1);
    bus.req_valid = 1'b1;
    bus.rn        = rn;
    bus.rm        = rm;
    bus.shift     = sh;
    @(negedge clk);
    bus.req_valid = 1'($urandom_range(0, 1));
    bus.rn        = 3'($urandom);
    bus.rm        = 3'($urandom);
    bus.shift     = 2'($urandom);
    bus.out_ready = 1'b1;
    write         = aWr;
    writenum      = aWn;
    write_data    = aWd;
    expA = (aWr && aWn == rn) ? aWd : regs[rn];
    @(posedge clk);
    #1;
    if (aWr) regs[aWn] = aWd;
    write = 1'b0;
    @(negedge clk);
    checkOutput({tag, ".aOut"}, bus.a_out, expA);
    checkOutput({tag, ".validLowA"}, {15'b0, bus.out_valid}, 16'h0);
    write      = bWr;
    writenum   = bWn;
    write_data = bWd;
    srcB = (bWr && bWn == rm) ? bWd : regs[rm];
    expB = shiftRef(srcB, sh);
    @(posedge clk);
    #1;
    if (bWr) regs[bWn] = bWd;
    write         = 1'b0;
    bus.out_ready = 1'b0;
    bus.req_valid = 1'b0;
    @(negedge clk);
    checkOutput({tag, ".validHigh"}, {15'b0, bus.out_valid}, 16'h1);
    checkOutput({tag, ".bOut"}, bus.b_out, expB);
    checkOutput({tag, ".aHold"}, bus.a_out, expA);
    checkOutput({tag, ".readyLow"}, {15'b0, bus.req_ready}, 16'h0);
    for (int i = 0; i < holdCycles; i++) begin
      @(negedge clk);
      checkOutput({tag, ".stallValid"}, {15'b0, bus.out_valid}, 16'h1);
      checkOutput({tag, ".stallA"}, bus.a_out, expA);
      checkOutput({tag, ".stallB"}, bus.b_out, expB);
      checkOutput({tag, ".stallReady"}, {15'b0, bus.req_ready}, 16'h0);
    end
    bus.out_ready = 1'b1;
    bus.req_valid = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.req_valid = 1'b0;
    checkOutput({tag, ".backIdle"}, {15'b0, bus.req_ready}, 16'h1);
    checkOutput({tag, ".validDrop"}, {15'b0, bus.out_valid}, 16'h0);
  endtask

  initial begin
    logic [2:0] rRn, rRm, rWn;
    checks        = 0;
    fails         = 0;
    write         = 1'b0;
    writenum      = 3'd0;
    write_data    = 16'h0;
    bus.req_valid = 1'b0;
    bus.rn        = 3'd0;
    bus.rm        = 3'd0;
    bus.shift     = 2'd0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) regs[i] = 16'h1111 * 16'(i);
    reset_n = 1'b0;
    #2;
    checkOutput("reset.ready", {15'b0, bus.req_ready}, 16'h1);
    checkOutput("reset.valid", {15'b0, bus.out_valid}, 16'h0);
    checkOutput("reset.a", bus.a_out, 16'h0);
    checkOutput("reset.b", bus.b_out, 16'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    regs[2] = 16'h1234;
    regs[5] = 16'h00FF;
    applyStimulus("basic", 3'd2, 3'd5, 2'd0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 0);

    regs[1] = 16'h8001;
    applyStimulus("lsl", 3'd0, 3'd1, 2'd1, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 0);
    checkOutput("lsl.value", bus.b_out, 16'h0002);
    applyStimulus("lsr", 3'd0, 3'd1, 2'd2, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 0);
    checkOutput("lsr.value", bus.b_out, 16'h4000);
    applyStimulus("asr", 3'd0, 3'd1, 2'd3, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 0);
    checkOutput("asr.value", bus.b_out, 16'hC000);

    regs[3] = 16'h0000;
    applyStimulus("bypassA", 3'd3, 3'd0, 2'd0, 1'b1, 3'd3, 16'hBEEF, 1'b0, 3'd0, 16'h0, 0);
    checkOutput("bypassA.value", bus.a_out, 16'hBEEF);
    regs[3] = 16'h0000;
    applyStimulus("otherWrite", 3'd3, 3'd0, 2'd0, 1'b1, 3'd4, 16'hCAFE, 1'b0, 3'd0, 16'h0, 0);
    checkOutput("otherWrite.value", bus.a_out, 16'h0000);
    applyStimulus("betweenAB", 3'd6, 3'd6, 2'd0, 1'b1, 3'd6, 16'h5A5A, 1'b0, 3'd0, 16'h0, 0);
    applyStimulus("bypassB", 3'd7, 3'd7, 2'd1, 1'b0, 3'd0, 16'h0, 1'b1, 3'd7, 16'hF00D, 0);

    applyStimulus("backpressure", 3'd4, 3'd2, 2'd0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 5);

    // Abort mid READ_B, then confirm the block recovers cleanly.
    bus.req_valid = 1'b1;
    bus.rn        = 3'd2;
    bus.rm        = 3'd5;
    bus.shift     = 2'd3;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    checkOutput("midReset.ready", {15'b0, bus.req_ready}, 16'h1);
    checkOutput("midReset.valid", {15'b0, bus.out_valid}, 16'h0);
    checkOutput("midReset.a", bus.a_out, 16'h0);
    checkOutput("midReset.b", bus.b_out, 16'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("midReset.stayIdle", {15'b0, bus.out_valid}, 16'h0);
    regs[2] = 16'hA5A5;
    regs[5] = 16'h8421;
    applyStimulus("afterReset", 3'd2, 3'd5, 2'd2, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 1);

    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 8; i++) regs[i] = 16'($urandom);
      rRn = 3'($urandom);
      rRm = 3'($urandom);
      rWn = 3'($urandom);
      applyStimulus("random", rRn, rRm, 2'($urandom),
                    1'($urandom_range(0, 1)), ($urandom_range(0, 1) == 1) ? rRn : rWn, 16'($urandom),
                    1'($urandom_range(0, 1)), ($urandom_range(0, 1) == 1) ? rRm : rWn, 16'($urandom),
                    $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
